// File: rtl/sad_arbiter.sv
// Two-requester arbiter sequencing jobs on a shared SAD controller.
// Ties go to whichever requester was not served last; a stuck job is aborted by a cycle timeout.
module sad_arbiter #(
    parameter int TIMEOUT = 1023,
    parameter int SUM_W   = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [1:0]       req,
    output logic [1:0]       gnt,
    output logic [1:0]       ack,
    output logic             err,
    output logic             go,
    input  logic             done,
    output logic             ctrl_rst,
    input  logic [SUM_W-1:0] sum_in,
    output logic [SUM_W-1:0] result,
    output logic             bank_sel
);

    // state | meaning
    // IDLE  | no job; waiting for a request
    // START | go pulse to the SAD controller, grant asserted
    // BUSY  | waiting for done; counting cycles toward the timeout
    // ACK   | successful completion pulse to the granted requester
    // ABORT | timeout completion pulse plus controller abort
    typedef enum logic [2:0] {IDLE, START, BUSY, ACK, ABORT} state_t;

    localparam logic [9:0] TC = 10'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic             g, g_nxt;
    logic             last_served, last_nxt;
    logic [9:0]       cnt, cnt_nxt;
    logic             capture;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            g           <= 1'b0;
            last_served <= 1'b1;
            cnt         <= 10'd0;
            result      <= '0;
        end else begin
            state       <= state_nxt;
            g           <= g_nxt;
            last_served <= last_nxt;
            cnt         <= cnt_nxt;
            if (capture)
                result <= sum_in;
        end
    end

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        last_nxt  = last_served;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        gnt       = 2'b00;
        ack       = 2'b00;
        err       = 1'b0;
        go        = 1'b0;
        ctrl_rst  = 1'b0;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    state_nxt = START;
                    g_nxt     = (req == 2'b11) ? ~last_served : req[1];
                end
            end
            START: begin
                gnt[g]    = 1'b1;
                go        = 1'b1;
                cnt_nxt   = 10'd0;
                state_nxt = BUSY;
            end
            BUSY: begin
                gnt[g] = 1'b1;
                // done takes priority over a timeout landing on the same edge
                if (done) begin
                    capture   = 1'b1;
                    state_nxt = ACK;
                end else if (cnt == TC) begin
                    state_nxt = ABORT;
                end else begin
                    cnt_nxt = cnt + 10'd1;
                end
            end
            ACK: begin
                gnt[g]    = 1'b1;
                ack[g]    = 1'b1;
                last_nxt  = g;
                state_nxt = IDLE;
            end
            ABORT: begin
                gnt[g]    = 1'b1;
                ack[g]    = 1'b1;
                err       = 1'b1;
                ctrl_rst  = 1'b1;
                last_nxt  = g;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bank_sel = g;

endmodule

// File: tb/tb_sad_arbiter.sv
// Self-checking bench for sad_arbiter: directed scenarios plus randomized jobs
// checked against a job-level timing model (grant choice, job length, outcome).
module tb_sad_arbiter;

    localparam int TO = 8;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [1:0]  ack;
    logic        err;
    logic        go;
    logic        done;
    logic        ctrl_rst;
    logic [31:0] sum_in;
    logic [31:0] result;
    logic        bank_sel;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        last_served_m;
    logic [31:0] result_m;

    sad_arbiter #(.TIMEOUT(TO), .SUM_W(32)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .req      (req),
        .gnt      (gnt),
        .ack      (ack),
        .err      (err),
        .go       (go),
        .done     (done),
        .ctrl_rst (ctrl_rst),
        .sum_in   (sum_in),
        .result   (result),
        .bank_sel (bank_sel)
    );

    always #5 Clk = ~Clk;

    // One job: request r, done raised in BUSY cycle n_done (0 = never), sum s.
    // Called at a negedge while the DUT is idle; returns at the negedge of the
    // following idle cycle with all checks done.
    task automatic run_job(input logic [1:0] r, input int n_done, input logic [31:0] s,
                           input bit drop, input string name);
        logic       g;
        logic [1:0] oh;
        bit         e;
        int         len;
        logic [7:0] obs, exp_v;
        g   = (r == 2'b11) ? ~last_served_m : r[1];
        oh  = g ? 2'b10 : 2'b01;
        e   = (n_done == 0) || (n_done > TO);
        len = e ? TO : n_done;
        req = r; sum_in = s; done = 1'b0;
        @(negedge Clk);
        obs   = {gnt, ack, err, go, ctrl_rst, bank_sel};
        exp_v = {oh, 2'b00, 1'b0, 1'b1, 1'b0, g};
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s start: got %b want %b (gnt,ack,err,go,ctrl_rst,bank_sel)", name, obs, exp_v);
        end
        if (drop) req = 2'b00;
        for (int i = 1; i <= len; i++) begin
            @(negedge Clk);
            obs   = {gnt, ack, err, go, ctrl_rst, bank_sel};
            exp_v = {oh, 2'b00, 1'b0, 1'b0, 1'b0, g};
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL %s busy%0d: got %b want %b", name, i, obs, exp_v);
            end
            done = (i == n_done);
        end
        @(negedge Clk);
        done  = 1'b0;
        obs   = {gnt, ack, err, go, ctrl_rst, bank_sel};
        exp_v = {oh, oh, e, 1'b0, e, g};
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s end: got %b want %b", name, obs, exp_v);
        end
        @(negedge Clk);
        if (!e) result_m = s;
        last_served_m = g;
        obs   = {gnt, ack, err, go, ctrl_rst, bank_sel};
        exp_v = {2'b00, 2'b00, 1'b0, 1'b0, 1'b0, g};
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s idle: got %b want %b", name, obs, exp_v);
        end
        n_cmp++;
        if (result !== result_m) begin
            n_bad++;
            $display("FAIL %s result: got %h want %h", name, result, result_m);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1; req = 2'b00; done = 1'b0; sum_in = 32'hDEAD_BEEF;
        last_served_m = 1'b1; result_m = 32'h0;
        #3;
        n_cmp++;
        if ({gnt, ack, err, go, ctrl_rst, bank_sel, result} !== 40'h0) begin
            n_bad++;
            $display("FAIL reset: got %b / %h want all zero", {gnt, ack, err, go, ctrl_rst, bank_sel}, result);
        end
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic test_contention();
        for (int j = 0; j < 4; j++)
            run_job(2'b11, 3, 32'h100 + 32'(j), 1'b0, "contention");
        req = 2'b00;
    endtask

    task automatic test_single();
        run_job(2'b01, 5, 32'h0000_01F4, 1'b0, "single");
        req = 2'b00;
    endtask

    task automatic test_timeout();
        run_job(2'b10, 0, 32'h5555_AAAA, 1'b0, "timeout");
        req = 2'b00;
    endtask

    task automatic test_done_timeout_tie();
        run_job(2'b10, TO, 32'h1234_5678, 1'b0, "tie");
        req = 2'b00;
    endtask

    task automatic test_robust();
        run_job(2'b01, 4, $urandom, 1'b1, "drop_req");
        req = 2'b00;
        sum_in = $urandom;
        done = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk);
            done = 1'b0;
            n_cmp++;
            if ({gnt, ack, err, go, ctrl_rst, bank_sel} !== {7'b0, last_served_m} || result !== result_m) begin
                n_bad++;
                $display("FAIL idle_done: got %b / %h want %b / %h", {gnt, ack, err, go, ctrl_rst, bank_sel},
                         result, {7'b0, last_served_m}, result_m);
            end
        end
    endtask

    task automatic test_async_reset();
        req = 2'b10; sum_in = 32'hCAFE_0001;
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        #1;
        n_cmp++;
        if ({gnt, ack, err, go, ctrl_rst, bank_sel, result} !== 40'h0) begin
            n_bad++;
            $display("FAIL async_reset: got %b / %h want all zero", {gnt, ack, err, go, ctrl_rst, bank_sel}, result);
        end
        #1;
        Rst = 1'b0; req = 2'b00;
        last_served_m = 1'b1; result_m = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            n_cmp++;
            if ({gnt, ack, err, go, ctrl_rst, bank_sel} !== 8'h00) begin
                n_bad++;
                $display("FAIL post_reset_idle: got %b want 00000000", {gnt, ack, err, go, ctrl_rst, bank_sel});
            end
        end
        run_job(2'b11, 2, 32'h0BAD_F00D, 1'b0, "reset_tie");
        req = 2'b00;
    endtask

    task automatic test_random();
        for (int j = 0; j < 40; j++) begin
            run_job(2'($urandom_range(1, 3)), int'($urandom_range(0, 11)), $urandom,
                    1'($urandom_range(0, 1)), "random");
            if ($urandom_range(0, 3) == 0) begin
                req = 2'b00;
                @(negedge Clk);
                n_cmp++;
                if ({gnt, ack, err, go, ctrl_rst, bank_sel} !== {7'b0, last_served_m}) begin
                    n_bad++;
                    $display("FAIL random_gap: got %b want %b", {gnt, ack, err, go, ctrl_rst, bank_sel},
                             {7'b0, last_served_m});
                end
            end
        end
        req = 2'b00;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_timeout();
        test_done_timeout_tie();
        test_robust();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sad_arbiter.md
SAD_ARBITER -- requirements
Module: sad_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1023: number of BUSY cycles allowed before a job is aborted; legal range 2..1023.
REQ-002 Parameter SUM_W, default 32: width of the sum result.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  2  per-requester job request; level-sensitive.
REQ-006 gnt  output  2  one-hot grant, held for the whole job; 2'b00 when idle.
REQ-007 ack  output  2  one-cycle completion pulse to the granted requester.
REQ-008 err  output  1  valid with ack; 1 = job aborted by timeout.
REQ-009 go  output  1  start pulse to the SAD controller.
REQ-010 done  input  1  completion flag from the SAD controller.
REQ-011 ctrl_rst  output  1  one-cycle synchronous abort pulse to the SAD controller.
REQ-012 sum_in  input  SUM_W  SAD datapath sum register output.
REQ-013 result  output  SUM_W  sum captured at the last successful completion.
REQ-014 bank_sel  output  1  memory bank select; equals the index of the granted requester.

Function
REQ-015 States SHALL be IDLE, START, BUSY, ACK and ABORT; all outputs are Moore outputs decoded from registered state, grant index and counter.
REQ-016 In IDLE, gnt, ack, err, go and ctrl_rst SHALL be 0, and bank_sel SHALL hold its last value.
REQ-017 In IDLE, with any req bit high at an edge, the state SHALL move to START and latch grant index g.
- Single request: g = the requesting index.
- Both requests: g = the index not equal to last_served.
REQ-018 START SHALL last exactly one cycle.
- gnt[g]=1, bank_sel=g, go=1.
- Then BUSY; the cycle counter is cleared to 0.
REQ-019 In BUSY, gnt[g] SHALL stay 1 and go=0.
- The counter increments by 1 on each BUSY edge without done.
- The counter is 10 bits and SHALL never wrap in normal operation.
REQ-020 In BUSY with done=1 at an edge:
- result <= sum_in.
- Next state is ACK.
REQ-021 In BUSY with done=0 and counter = TIMEOUT-1 at an edge, the next state SHALL be ABORT; result is unchanged.
REQ-022 If done=1 and the timeout condition hold on the same edge, done SHALL win (ACK, err=0).
REQ-023 ACK SHALL last one cycle.
- gnt[g]=1, ack[g]=1, err=0.
- Then IDLE, with last_served <= g.
REQ-024 ABORT SHALL last one cycle.
- gnt[g]=1, ack[g]=1, err=1, ctrl_rst=1.
- Then IDLE, with last_served <= g.
REQ-025 Deassertion of req[g] during START, BUSY, ACK or ABORT SHALL be ignored; the job runs to ACK or ABORT.
REQ-026 done SHALL be ignored in IDLE, START, ACK and ABORT.
REQ-027 At least one IDLE cycle SHALL separate consecutive jobs.
- Latency from req sampled to go is 1 cycle.
- Minimum job length is START + 1 BUSY + ACK = 3 cycles.
REQ-028 gnt SHALL be one-hot or zero at all times, and ack SHALL never be asserted for a non-granted index.

Reset
REQ-029 Rst=1 SHALL immediately force, regardless of Clk:
- state=IDLE, gnt=0, ack=0, err=0, go=0, ctrl_rst=0.
- counter=0, result=0, bank_sel=0, last_served=1 (requester 0 wins the first tie).
REQ-030 Reset asserted mid-job SHALL abandon the job without an ack pulse.
REQ-031 After Rst falls, the first request SHALL be sampled on the first rising edge.

Verification
REQ-032 Single request: req=2'b01 held, done raised 5 BUSY cycles after go with sum_in=32'h0000_01F4 ->
- go pulse 1 cycle after req sampled; gnt=2'b01 and bank_sel=0 throughout.
- ack=2'b01 with err=0; result=32'h1F4.
REQ-033 Contention: req=2'b11 held continuously, done after 3 cycles each job ->
- grants alternate 01,10,01,10.
- Each job separated by exactly one IDLE cycle.
REQ-034 Timeout: TIMEOUT=8, req=2'b10, done never asserted ->
- ABORT exactly 8 BUSY cycles after START.
- ctrl_rst=1, ack=2'b10 and err=1 in the same cycle; result unchanged.
REQ-035 Simultaneous done and timeout: TIMEOUT=8, done on the 8th BUSY edge -> ACK with err=0 and result captured.
REQ-036 Async reset mid-BUSY: Rst pulsed between clock edges ->
- all outputs 0 before the next edge; no ack issued.
- A subsequent req=2'b11 grants 2'b01 first.
REQ-037 Robustness: req dropped during BUSY, and done pulsed while IDLE ->
- the job still completes with an ack pulse.
- The IDLE done pulse causes no state change.
